// File: rtl/gpio_debounce.sv
// Two-flop synchroniser plus per-bit debounce for 8 GPIO input pins, with sticky
// edge flags and a bus-programmable threshold. GPIO_DEBOUNCE_IRQ_EN adds a mask register and irq.
module gpio_debounce #(
   parameter logic [31:0] ADDR           = 32'hffff_fff0,
   parameter int          CNT_W          = 16,
   parameter logic [15:0] DEFAULT_THRESH = 16'd1000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        dbnc_ready,
   output logic        dbnc_sel,
   output logic [31:0] dbnc_rdata,
   input  logic [7:0]  pin_raw,
   output logic [7:0]  pin_clean
`ifdef GPIO_DEBOUNCE_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam logic [31:0]      THRESH_RST_W = 32'(DEFAULT_THRESH);
   localparam logic [CNT_W-1:0] THRESH_RST   = THRESH_RST_W[CNT_W-1:0];

   logic [7:0]             s1_q, s2_q;
   logic [7:0]             clean_q, clean_d;
   logic [7:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]             rise_q, rise_d, fall_q, fall_d;
   logic [CNT_W-1:0]       thresh_q, thresh_d;
   logic                   hit_pin, hit_stat, hit_thr, wr_en;
   logic [7:0]             clr_rise, clr_fall;
   logic                   unused_bits;

`ifdef GPIO_DEBOUNCE_IRQ_EN
   logic [15:0]            mask_q, mask_d;
   logic                   hit_mask;
`endif

   assign dbnc_ready  = 1'b1;
   assign pin_clean   = clean_q;
   assign unused_bits = ^{mem_wdata[31:16], mem_wstrb[3:2]};

   always_comb begin
      hit_pin  = mem_valid && (mem_addr == ADDR);
      hit_stat = mem_valid && (mem_addr == ADDR + 32'd4);
      hit_thr  = mem_valid && (mem_addr == ADDR + 32'd8);
`ifdef GPIO_DEBOUNCE_IRQ_EN
      hit_mask = mem_valid && (mem_addr == ADDR + 32'd12);
      dbnc_sel = hit_pin || hit_stat || hit_thr || hit_mask;
`else
      dbnc_sel = hit_pin || hit_stat || hit_thr;
`endif
      wr_en    = dbnc_sel && (|mem_wstrb);
   end

   always_comb begin
      dbnc_rdata = '0;
      if (hit_pin)
         dbnc_rdata = {24'b0, clean_q};
      else if (hit_stat)
         dbnc_rdata = {16'b0, fall_q, rise_q};
      else if (hit_thr)
         dbnc_rdata[CNT_W-1:0] = thresh_q;
`ifdef GPIO_DEBOUNCE_IRQ_EN
      else if (hit_mask)
         dbnc_rdata[15:0] = mask_q;
`endif
   end

   // A bit flips only after thresh+1 consecutive mismatched samples, so cnt never passes thresh.
   always_comb begin
      clean_d = clean_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 8; i++) begin
         if (s2_q[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= thresh_q) begin
            clean_d[i] = s2_q[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Set has priority over a same-cycle write-1-to-clear so no edge is lost.
   always_comb begin
      clr_rise = (wr_en && hit_stat && mem_wstrb[0]) ? mem_wdata[7:0]  : 8'h00;
      clr_fall = (wr_en && hit_stat && mem_wstrb[1]) ? mem_wdata[15:8] : 8'h00;
      rise_d   = (rise_q & ~clr_rise) | (clean_d & ~clean_q);
      fall_d   = (fall_q & ~clr_fall) | (~clean_d & clean_q);
   end

   always_comb begin
      thresh_d = thresh_q;
      if (wr_en && hit_thr) begin
         for (int b = 0; b < CNT_W; b++) begin
            if (b < 8 && mem_wstrb[0])
               thresh_d[b] = mem_wdata[b];
            else if (b >= 8 && b < 16 && mem_wstrb[1])
               thresh_d[b] = mem_wdata[b];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_q     <= '0;
         s2_q     <= '0;
         clean_q  <= '0;
         cnt_q    <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         thresh_q <= THRESH_RST;
      end else begin
         s1_q     <= pin_raw;
         s2_q     <= s1_q;
         clean_q  <= clean_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         thresh_q <= thresh_d;
      end
   end

`ifdef GPIO_DEBOUNCE_IRQ_EN
   always_comb begin
      mask_d = mask_q;
      if (wr_en && hit_mask) begin
         if (mem_wstrb[0]) mask_d[7:0]  = mem_wdata[7:0];
         if (mem_wstrb[1]) mask_d[15:8] = mem_wdata[15:8];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         mask_q <= '0;
      else
         mask_q <= mask_d;
   end

   assign irq = |({fall_q, rise_q} & mask_q);
`endif

endmodule

// File: doc/gpio_debounce.md
Name: gpio_debounce

Overview:
- Input conditioning stage directly upstream of the GPIO block.
- Synchronises and debounces 8 raw input pins, then drives the clean value into the GPIO block's pin-input port.
- Exposes the clean value, sticky edge-status flags and a programmable debounce threshold on the same single-cycle memory bus as the GPIO block.

Parameters:
- ADDR, 32'hffff_fff0: base address, word aligned. Registers at ADDR, +4, +8 and +12 (the last only with the feature).
- CNT_W, 16: width of the per-bit debounce counters and the threshold register.
- DEFAULT_THRESH, 16'd1000: threshold reset value, truncated to CNT_W.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset; asynchronous, active-low
- mem_valid  input  1  bus request valid
- mem_addr  input  32  bus address
- mem_wdata  input  32  bus write data
- mem_wstrb  input  4  byte write strobes; all zero means read
- dbnc_ready  output  1  constant 1
- dbnc_sel  output  1  mem_valid and mem_addr matches a mapped register
- dbnc_rdata  output  32  read data, combinational
- pin_raw  input  8  asynchronous external pins
- pin_clean  output  8  debounced value; feeds the GPIO pin input
- irq  output  1  present only with GPIO_DEBOUNCE_IRQ_EN

Behaviour:
- Reset is asynchronous, active-low. On assertion:
  - sync stages, pin_clean, counters and status go to 0;
  - threshold goes to DEFAULT_THRESH;
  - mask (feature) goes to 0.
- Reset mid-count discards all debounce progress. Deassertion takes effect at the next clk edge.
- Synchroniser: pin_raw passes through two flops (s1 then s2) per bit. Nothing else samples pin_raw.
- Per-bit debounce, evaluated every cycle:
  - s2[i] == pin_clean[i]: cnt[i] <= 0.
  - Mismatch and cnt[i] >= thresh: pin_clean[i] <= s2[i], cnt[i] <= 0.
  - Mismatch otherwise: cnt[i] <= cnt[i] + 1. The counter saturates and cannot wrap, because it flips at or before the threshold.
- Latency: a raw change held stable appears on pin_clean exactly thresh+3 clock edges later. With thresh=0 that is 3 edges.
- A glitch shorter than thresh+1 sampled cycles never reaches pin_clean; its counter returns to 0.
- A threshold write takes effect on the next cycle. Counters already >= the new value flip on the next mismatched cycle.
- Edge status (ADDR+4):
  - bits 7:0 are rise flags, bits 15:8 are fall flags, 31:16 read 0;
  - a flag sets in the same cycle pin_clean[i] flips 0->1 (rise) or 1->0 (fall).
- Edge status clear is write-1-to-clear:
  - mem_wstrb[0] clears rise flags where mem_wdata[7:0]=1;
  - mem_wstrb[1] clears fall flags where mem_wdata[15:8]=1.
  - If set and clear hit the same bit in the same cycle, set wins.
- Register map (all accesses single-cycle; dbnc_ready is always 1):
  - ADDR: read {24'b0, pin_clean}; writes ignored.
  - ADDR+4: edge status, as above.
  - ADDR+8: threshold in bits CNT_W-1:0, read/write per byte lane (wstrb[0] -> bits 7:0, wstrb[1] -> bits 15:8). Upper bits read 0.
- Writes occur only when dbnc_sel is high and mem_wstrb is nonzero.
- dbnc_rdata is 0 whenever dbnc_sel is low.

Optional Feature:
- Macro: GPIO_DEBOUNCE_IRQ_EN.
- Defined:
  - adds a mask register at ADDR+12, bits 15:0, read/write per byte lane, reset 0;
  - irq = |(status[15:0] & mask[15:0]), combinational from registers;
  - ADDR+12 is included in dbnc_sel.
- Undefined:
  - no irq port and no mask register;
  - ADDR+12 is not selected and reads 0 with sel low.

Test Plan:
- Reset with resetn=0 asynchronously (mid-cycle) -> pin_clean=0, status=0, read ADDR+8 returns DEFAULT_THRESH, dbnc_ready=1.
- Write ADDR+8=4, drive pin_raw[0] 0->1 and hold -> pin_clean[0] rises exactly 7 edges later; ADDR+4 reads 0x0000_0001.
- thresh=4, pulse pin_raw[3] high for 4 cycles -> pin_clean[3] stays 0 and status stays 0. Repeat with a 5-cycle pulse -> rise then fall; status reads 0x0000_0808.
- status=0x0101, write ADDR+4 data 0x0100 with wstrb=4'b0010 -> reads 0x0001. Write 0x0001 with wstrb=4'b0001 in the same cycle a new rise on bit 0 occurs -> bit 0 stays 1.
- thresh=0, toggle pin_raw=8'hA5 -> pin_clean=8'hA5 after 3 edges. Read ADDR+12 without the feature -> dbnc_sel=0, rdata=0. Read unmapped ADDR+16 -> dbnc_sel=0.
- With GPIO_DEBOUNCE_IRQ_EN: mask=0x0002, rise on bit 1 -> irq=1 the same cycle pin_clean[1] rises. Clear bit 1 via ADDR+4 -> irq=0 on the next cycle.
